// File: rtl/register_file_32x32_pkg.sv
// Shared CPU definitions for the 32-entry register file: sizes and clear-sweep FSM encoding.
package register_file_32x32_pkg;

  localparam int unsigned NumRegs = 32;
  localparam int unsigned AddrW   = 5;

  typedef enum logic {
    StIdle,
    StClear
  } rf_state_e;

endpackage

// File: rtl/decoder_5_32.sv
// 5-to-32 one-hot decoder with a global enable; all outputs low when disabled.
module decoder_5_32 (
  input  logic        en,
  input  logic [4:0]  addr,
  output logic [31:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/register_file_32x32.sv
// 32-entry, two-read/one-write register file with write-to-read bypass and a
// 32-cycle clear sweep that stalls writes while it runs.
module register_file_32x32
  import register_file_32x32_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        ra_addr,
  input  logic [4:0]        rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  rf_state_e            state_q, state_d;
  logic [AddrW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]    regs_q [NumRegs];
  logic                 wr_accept;
  logic [NumRegs-1:0]   wr_dec;
  logic [NumRegs-1:0]   wr_we;
  logic [NumRegs-1:0]   clr_we;

  // Sweep FSM: clr_req wins over a same-cycle write by dropping wr_ready immediately.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_ready = 1'b0;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        wr_ready = ~clr_req;
        if (clr_req) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        clr_busy = 1'b1;
        idx_d    = idx_q + 1'b1;
        if (idx_q == AddrW'(NumRegs - 1)) begin
          clr_done = 1'b1;
          state_d  = StIdle;
          idx_d    = '0;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign wr_accept = wr_valid & wr_ready;

  decoder_5_32 u_wr_dec (
    .en     (wr_accept),
    .addr   (wr_addr),
    .onehot (wr_dec)
  );

  always_comb begin
    wr_we = wr_dec;
    if (ZERO_R0) begin
      wr_we[0] = 1'b0;
    end
  end

  always_comb begin
    clr_we = '0;
    if (state_q == StClear) begin
      clr_we[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[AddrW'(i)] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        if (clr_we[AddrW'(i)]) begin
          regs_q[AddrW'(i)] <= '0;
        end else if (wr_we[AddrW'(i)]) begin
          regs_q[AddrW'(i)] <= wr_data;
        end
      end
    end
  end

  // wr_accept is never set during a sweep, so bypass is implicitly off there.
  always_comb begin
    ra_data = regs_q[ra_addr];
    if (ZERO_R0 && (ra_addr == '0)) begin
      ra_data = '0;
    end else if (wr_accept && (wr_addr == ra_addr)) begin
      ra_data = wr_data;
    end
  end

  always_comb begin
    rb_data = regs_q[rb_addr];
    if (ZERO_R0 && (rb_addr == '0)) begin
      rb_data = '0;
    end else if (wr_accept && (wr_addr == rb_addr)) begin
      rb_data = wr_data;
    end
  end

endmodule

// File: tb/tb_register_file_32x32.sv
// Directed self-checking bench for register_file_32x32: writes, bypass, r0, clear sweep, reset.
module tb_register_file_32x32;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

  int n_checks;
  int n_fails;

  register_file_32x32 #(
    .DATA_W  (32),
    .ZERO_R0 (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
  endtask

  function automatic logic [31:0] fill_val(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fails++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready);
    end
    n_checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      n_fails++; $display("FAIL reset_clr_flags: got busy=%b done=%b expected 0 0", clr_busy, clr_done);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) begin
      ra_addr = 5'(i);
      #1;
      n_checks++;
      if (ra_data !== 32'h0) begin
        n_fails++; $display("FAIL reset_reg[%0d]: got %h expected 0", i, ra_data);
      end
    end
  endtask

  task automatic test_write_read();
    write_reg(5'd5, 32'hDEADBEEF);
    ra_addr = 5'd5;
    #1;
    n_checks++;
    if (ra_data !== 32'hDEADBEEF) begin
      n_fails++; $display("FAIL write_read_r5: got %h expected deadbeef", ra_data);
    end
    for (int i = 0; i < 32; i++) begin
      if (i != 5) begin
        rb_addr = 5'(i);
        #1;
        n_checks++;
        if (rb_data !== 32'h0) begin
          n_fails++; $display("FAIL write_read_other[%0d]: got %h expected 0", i, rb_data);
        end
      end
    end
  endtask

  task automatic test_bypass();
    rb_addr  = 5'd9;
    ra_addr  = 5'd5;
    wr_valid = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'h12345678;
    #1;
    n_checks++;
    if (rb_data !== 32'h12345678) begin
      n_fails++; $display("FAIL bypass_rb: got %h expected 12345678", rb_data);
    end
    n_checks++;
    if (ra_data !== 32'hDEADBEEF) begin
      n_fails++; $display("FAIL bypass_ra_other: got %h expected deadbeef", ra_data);
    end
    tick();
    wr_valid = 1'b0;
    #1;
    n_checks++;
    if (rb_data !== 32'h12345678) begin
      n_fails++; $display("FAIL bypass_stored: got %h expected 12345678", rb_data);
    end
  endtask

  task automatic test_r0();
    ra_addr  = 5'd0;
    wr_valid = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if (ra_data !== 32'h0) begin
      n_fails++; $display("FAIL r0_same_cycle: got %h expected 0", ra_data);
    end
    tick();
    wr_valid = 1'b0;
    #1;
    n_checks++;
    if (ra_data !== 32'h0) begin
      n_fails++; $display("FAIL r0_next_cycle: got %h expected 0", ra_data);
    end
  endtask

  task automatic test_back_to_back();
    write_reg(5'd10, 32'h0000_1010);
    wr_valid = 1'b1;
    wr_addr  = 5'd11;
    wr_data  = 32'h0000_1111;
    ra_addr  = 5'd10;
    rb_addr  = 5'd11;
    #1;
    n_checks++;
    if (ra_data !== 32'h0000_1010 || rb_data !== 32'h0000_1111) begin
      n_fails++; $display("FAIL back_to_back: got %h %h expected 00001010 00001111", ra_data, rb_data);
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic fill_regs();
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), fill_val(i));
    end
  endtask

  task automatic test_clear_sweep();
    int done_cnt;
    done_cnt = 0;
    fill_regs();
    ra_addr = 5'd17;
    #1;
    n_checks++;
    if (ra_data !== fill_val(17)) begin
      n_fails++; $display("FAIL sweep_fill_r17: got %h expected %h", ra_data, fill_val(17));
    end
    clr_req = 1'b1;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fails++; $display("FAIL sweep_req_wr_ready: got %b expected 0", wr_ready);
    end
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      // Late write to an already-swept register and a re-request, both to be ignored.
      wr_valid = (k == 10);
      wr_addr  = 5'd3;
      wr_data  = 32'h5555_5555;
      clr_req  = (k == 20);
      ra_addr  = 5'(k);
      rb_addr  = (k == 10) ? 5'd3 : 5'(k - 1);
      #1;
      n_checks++;
      if (clr_busy !== 1'b1 || wr_ready !== 1'b0) begin
        n_fails++; $display("FAIL sweep_busy[%0d]: got busy=%b ready=%b expected 1 0", k, clr_busy, wr_ready);
      end
      n_checks++;
      if (clr_done !== (k == 31)) begin
        n_fails++; $display("FAIL sweep_done[%0d]: got %b expected %b", k, clr_done, (k == 31));
      end
      if (clr_done === 1'b1) done_cnt++;
      if (k > 0) begin
        n_checks++;
        if (ra_data !== fill_val(k)) begin
          n_fails++; $display("FAIL sweep_unswept[%0d]: got %h expected %h", k, ra_data, fill_val(k));
        end
        n_checks++;
        if (rb_data !== 32'h0) begin
          n_fails++; $display("FAIL sweep_swept[%0d]: got %h expected 0", k, rb_data);
        end
      end
      tick();
    end
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    #1;
    n_checks++;
    if (done_cnt != 1) begin
      n_fails++; $display("FAIL sweep_done_count: got %0d expected 1", done_cnt);
    end
    n_checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0 || wr_ready !== 1'b1) begin
      n_fails++; $display("FAIL sweep_end_flags: got busy=%b done=%b ready=%b expected 0 0 1", clr_busy, clr_done, wr_ready);
    end
    tick();
    n_checks++;
    if (clr_busy !== 1'b0) begin
      n_fails++; $display("FAIL sweep_req_not_queued: got busy=%b expected 0", clr_busy);
    end
    for (int i = 0; i < 32; i++) begin
      ra_addr = 5'(i);
      #1;
      n_checks++;
      if (ra_data !== 32'h0) begin
        n_fails++; $display("FAIL sweep_after[%0d]: got %h expected 0", i, ra_data);
      end
    end
  endtask

  task automatic test_simultaneous();
    int waited;
    waited = 0;
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'h0000_00AA;
    ra_addr  = 5'd3;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fails++; $display("FAIL simul_wr_ready: got %b expected 0", wr_ready);
    end
    n_checks++;
    if (ra_data !== 32'h0) begin
      n_fails++; $display("FAIL simul_no_bypass: got %h expected 0", ra_data);
    end
    tick();
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    while (clr_busy === 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    n_checks++;
    if (waited != 32) begin
      n_fails++; $display("FAIL simul_sweep_len: got %0d expected 32", waited);
    end
    #1;
    n_checks++;
    if (ra_data !== 32'h0) begin
      n_fails++; $display("FAIL simul_r3: got %h expected 0", ra_data);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int done_cnt;
    done_cnt = 0;
    fill_regs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (clr_done === 1'b1) done_cnt++;
      tick();
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0 || wr_ready !== 1'b1) begin
      n_fails++; $display("FAIL midrst_flags: got busy=%b done=%b ready=%b expected 0 0 1", clr_busy, clr_done, wr_ready);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra_addr = 5'(i);
      #1;
      n_checks++;
      if (ra_data !== 32'h0) begin
        n_fails++; $display("FAIL midrst_reg[%0d]: got %h expected 0", i, ra_data);
      end
    end
    for (int k = 0; k < 40; k++) begin
      if (clr_done === 1'b1) done_cnt++;
      tick();
    end
    n_checks++;
    if (done_cnt != 0 || clr_busy !== 1'b0) begin
      n_fails++; $display("FAIL midrst_no_done: got pulses=%0d busy=%b expected 0 0", done_cnt, clr_busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    ra_addr  = '0;
    rb_addr  = '0;
    clr_req  = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_back_to_back();
    test_clear_sweep();
    test_simultaneous();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
